// File: rtl/mmio_uart_if.sv
// mmio_uart_if: MMIO load/store bus between the memory mapper and the UART
interface mmio_uart_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_en;
  logic        read_en;
  logic [31:0] read_data;
  modport master (output address, write_data, write_en, read_en, input read_data);
  modport slave (input address, write_data, write_en, read_en, output read_data);
endinterface

// File: rtl/mmio_uart.sv
// mmio_uart: MMIO UART, TX FIFO + single-byte RX holding register.
// Optional `UART_LOOPBACK_EN adds STATUS bit8 loop_en (RX fed from TX, external txd held high).
module mmio_uart #(
  parameter int TX_FIFO_DEPTH  = 16,
  parameter int BAUD_DIV_RESET = 868
) (
  input  logic       clk,
  input  logic       reset,
  mmio_uart_if.slave bus,
  input  logic       rxd,
  output logic       txd
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  logic [1:0] sel;
  logic wr_tx, wr_st, wr_bd, rd_rx, push, pop, full, empty, loop_en, unused_ok;
  logic [7:0] fifo_q [TX_FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic [15:0] baud_q, div;
  state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_byte_q;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, sync_q;
  logic txd_q, txd_d, tx_end, rx_end, rx_done, rx_ok, rx_bad, rx_valid_q, ovr_q, fe_q;
  assign sel = bus.address[3:2];
  assign wr_tx = bus.write_en && sel == 2'd0;
  assign wr_st = bus.write_en && sel == 2'd2;
  assign wr_bd = bus.write_en && sel == 2'd3;
  assign rd_rx = bus.read_en && sel == 2'd1;
  assign unused_ok = ^{bus.address[31:4], bus.address[1:0], bus.write_data[31:16]};
  assign empty = wp_q == rp_q;
  assign full = wp_q[AW-1:0] == rp_q[AW-1:0] && wp_q[AW] != rp_q[AW];
  assign pop = tx_state_q == IDLE && !empty;
  assign push = wr_tx && (!full || pop);
  assign div = baud_q == '0 ? 16'd1 : baud_q;
  assign tx_end = tx_cnt_q == tx_div_q - 16'd1;
  assign rx_end = rx_cnt_q == rx_div_q - 16'd1;
  assign rx_half = rx_div_q[15:1] == '0 ? 16'd1 : {1'b0, rx_div_q[15:1]};
  assign rx_ok = rx_done && sync_q[1];
  assign rx_bad = rx_done && !sync_q[1];
`ifdef UART_LOOPBACK_EN
  logic loop_q;
  always_ff @(posedge clk)
    if (reset) loop_q <= 1'b0;
    else if (wr_st) loop_q <= bus.write_data[8];
  assign loop_en = loop_q;
`else
  assign loop_en = 1'b0;
`endif
  assign txd = loop_en ? 1'b1 : txd_q;
  assign bus.read_data = sel == 2'd1 ? {23'b0, rx_valid_q, rx_byte_q}
                       : sel == 2'd2 ? {23'b0, loop_en, 2'b0, fe_q, tx_state_q != IDLE, ovr_q, rx_valid_q, empty, full}
                       : sel == 2'd3 ? {16'b0, baud_q} : 32'b0;
  always_ff @(posedge clk)
    if (push) fifo_q[wp_q[AW-1:0]] <= bus.write_data[7:0];
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = tx_end ? '0 : tx_cnt_q + 16'd1;
    tx_div_d = tx_end ? div : tx_div_q;
    tx_sh_d = tx_sh_q;
    tx_bit_d = tx_bit_q;
    txd_d = txd_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (!empty) begin
          tx_state_d = START;
          tx_sh_d = fifo_q[rp_q[AW-1:0]];
          tx_div_d = div;
          txd_d = 1'b0;
        end
      end
      START: if (tx_end) begin
        tx_state_d = DATA;
        tx_bit_d = '0;
        txd_d = tx_sh_q[0];
      end
      DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_state_d = tx_bit_q == 3'd7 ? STOP : DATA;
        txd_d = tx_bit_q == 3'd7 ? 1'b1 : tx_sh_q[1];
      end
      default: if (tx_end) begin
        tx_state_d = IDLE;
        txd_d = 1'b1;
      end
    endcase
  end
  // START samples at mid-bit; each later sample is one bit period after the previous one
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_div_d = rx_div_q;
    rx_sh_d = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_done = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_div_d = div;
        if (sync_q[2] && !sync_q[1]) rx_state_d = START;
      end
      START: if (rx_cnt_q == rx_half - 16'd1) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_div_d = div;
        rx_state_d = sync_q[1] ? IDLE : DATA;
      end
      DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_div_d = div;
        rx_sh_d = {sync_q[1], rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_state_d = rx_bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (rx_end) begin
        rx_cnt_d = '0;
        rx_state_d = IDLE;
        rx_done = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      baud_q <= 16'(BAUD_DIV_RESET);
      tx_state_q <= IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= 16'd1;
      tx_sh_q <= '0;
      tx_bit_q <= '0;
      txd_q <= 1'b1;
      sync_q <= '1;
      rx_state_q <= IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= 16'd1;
      rx_sh_q <= '0;
      rx_bit_q <= '0;
      rx_byte_q <= '0;
      rx_valid_q <= 1'b0;
      ovr_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      wp_q <= wp_q + {{AW{1'b0}}, push};
      rp_q <= rp_q + {{AW{1'b0}}, pop};
      if (wr_bd) baud_q <= bus.write_data[15:0];
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_sh_q <= tx_sh_d;
      tx_bit_q <= tx_bit_d;
      txd_q <= txd_d;
      sync_q <= {sync_q[1:0], loop_en ? txd_q : rxd};
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_sh_q <= rx_sh_d;
      rx_bit_q <= rx_bit_d;
      if (rx_ok && (!rx_valid_q || rd_rx)) rx_byte_q <= rx_sh_q;
      rx_valid_q <= rx_ok ? 1'b1 : rd_rx ? 1'b0 : rx_valid_q;
      ovr_q <= (rx_ok && rx_valid_q && !rd_rx) || (ovr_q && !(wr_st && bus.write_data[3]));
      fe_q <= rx_bad || (fe_q && !(wr_st && bus.write_data[5]));
    end
  end
endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed + randomized checks of the MMIO UART against a frame-level model
module tb_mmio_uart;
  logic clk = 1'b0, reset = 1'b1, rxd = 1'b1, txd, rec = 1'b0;
  int checks = 0, errors = 0;
  logic [7:0] expq[$];
  logic txs[$];
  mmio_uart_if bus();
  mmio_uart #(.TX_FIFO_DEPTH(16), .BAUD_DIV_RESET(868)) dut (.clk(clk), .reset(reset), .bus(bus), .rxd(rxd), .txd(txd));
  always #5 clk = ~clk;
  always @(negedge clk) if (rec) txs.push_back(txd);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address = a;
    bus.write_data = d;
    bus.write_en = 1'b1;
    tick();
    bus.write_en = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d, input logic re);
    bus.address = a;
    bus.read_en = re;
    #1;
    d = bus.read_data;
    if (re) begin
      tick();
      bus.read_en = 1'b0;
    end
  endtask
  task automatic wait_tx_idle(input int bound);
    logic [31:0] st;
    int n;
    for (n = 0; n < bound; n++) begin
      rd(32'h8, st, 1'b0);
      if (!st[4] && st[1]) break;
      tick();
    end
    chk("tx_drain_in_time", 32'(n < bound), 32'd1);
    repeat (2) tick();
  endtask
  // Expected line per byte: start, 8 data LSB first, stop (d clocks each), then one idle clock
  task automatic check_tx(input int d);
    int idx = 0, mism;
    logic e;
    while (idx < txs.size() && txs[idx] !== 1'b0) idx++;
    for (int k = 0; k < expq.size(); k++) begin
      mism = 0;
      for (int i = 0; i <= 10 * d; i++) begin
        e = (i / d == 0) ? 1'b0 : (i / d >= 9) ? 1'b1 : expq[k][i / d - 1];
        if (idx + i >= txs.size() || txs[idx + i] !== e) mism++;
      end
      chk($sformatf("tx_byte%0d_%02h_bad_samples", k, expq[k]), mism, 0);
      idx += 10 * d + 1;
    end
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    for (int i = 0; i < 10; i++) begin
      rxd = i == 0 ? 1'b0 : i == 9 ? stop : b[i - 1];
      repeat (d) tick();
    end
    rxd = 1'b1;
    repeat (d + 6) tick();
  endtask
  initial begin
    logic [31:0] st;
    logic [7:0] b;
    int d, n, busy;
    bus.address = '0;
    bus.write_data = '0;
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    rd(32'h1000_0008, st, 1'b0); chk("reset_status", st, 32'h2);
    rd(32'hC, st, 1'b0); chk("reset_baud", st, 32'd868);
    rd(32'h0, st, 1'b0); chk("txdata_reads_0", st, 32'h0);
    rd(32'h4, st, 1'b0); chk("reset_rxdata", st, 32'h0);
    chk("reset_txd", txd, 1'b1);
    wr(32'hC, 32'hFFFF_0004);
    rd(32'hC, st, 1'b0); chk("baud_upper_ignored", st, 32'h4);
    txs.delete(); expq.delete(); rec = 1'b1;
    wr(32'h0, 32'hA5); expq.push_back(8'hA5);
    busy = 0;
    for (n = 0; n < 200; n++) begin
      rd(32'h8, st, 1'b0);
      if (st[4]) busy++;
      else if (busy > 0) break;
      tick();
    end
    chk("busy_cycles_a5", busy, 40);
    chk("status_after_a5", st, 32'h2);
    tick();
    check_tx(4);
    txs.delete(); expq.delete();
    for (int i = 0; i < 18; i++) begin
      wr(32'h0, 32'(i));
      if (i < 17) expq.push_back(8'(i));
      if (i == 15) begin rd(32'h8, st, 1'b0); chk("not_full_after_16_pushes", st[0], 1'b0); end
      if (i == 16) begin rd(32'h8, st, 1'b0); chk("full_after_17_pushes", st[0], 1'b1); end
    end
    rd(32'h8, st, 1'b0); chk("full_after_drop", st[0], 1'b1);
    wait_tx_idle(1000);
    check_tx(4);
    for (int r = 0; r < 4; r++) begin
      d = r == 0 ? 0 : $urandom_range(1, 6);
      wr(32'hC, 32'(d));
      txs.delete(); expq.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        wr(32'h0, {24'b0, b});
        expq.push_back(b);
      end
      wait_tx_idle(400);
      check_tx(d == 0 ? 1 : d);
    end
    rec = 1'b0;
    wr(32'hC, 32'd4);
    send_rx(8'h3C, 1'b1, 4);
    rd(32'h8, st, 1'b0); chk("rx_valid_3c", st, 32'h6);
    rd(32'h4, st, 1'b0); chk("rxdata_3c", st, 32'h13C);
    rd(32'h4, st, 1'b1);
    rd(32'h8, st, 1'b0); chk("rx_valid_cleared", st, 32'h2);
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(4, 10);
      b = 8'($urandom);
      wr(32'hC, 32'(d));
      send_rx(b, 1'b1, d);
      rd(32'h4, st, 1'b1); chk($sformatf("rx_rand_%0d_div%0d", r, d), st, {23'b0, 1'b1, b});
    end
    wr(32'hC, 32'd4);
    send_rx(8'h11, 1'b1, 4);
    send_rx(8'h22, 1'b1, 4);
    rd(32'h4, st, 1'b0); chk("overrun_keeps_old", st, 32'h111);
    rd(32'h8, st, 1'b0); chk("overrun_set", st, 32'hE);
    wr(32'h8, 32'h8);
    rd(32'h8, st, 1'b0); chk("overrun_cleared", st, 32'h6);
    send_rx(8'($urandom), 1'b0, 4);
    rd(32'h8, st, 1'b0); chk("frame_err_set", st, 32'h26);
    rd(32'h4, st, 1'b0); chk("frame_err_keeps_byte", st, 32'h111);
    rxd = 1'b0; tick(); rxd = 1'b1;
    repeat (20) tick();
    rd(32'h8, st, 1'b0); chk("glitch_ignored", st, 32'h26);
    rd(32'h4, st, 1'b0); chk("glitch_no_byte", st, 32'h111);
    wr(32'h8, 32'h20);
    rd(32'h8, st, 1'b0); chk("frame_err_cleared", st, 32'h6);
    wr(32'h0, 32'h00);
    wr(32'h0, 32'hFF);
    repeat (10) tick();
    chk("txd_low_mid_frame", txd, 1'b0);
    reset = 1'b1;
    tick();
    chk("txd_after_reset", txd, 1'b1);
    reset = 1'b0;
    rd(32'h8, st, 1'b0); chk("status_after_reset", st, 32'h2);
    rd(32'hC, st, 1'b0); chk("baud_after_reset", st, 32'd868);
    wr(32'hC, 32'd4);
`ifdef UART_LOOPBACK_EN
    wr(32'h8, 32'h100);
    rd(32'h8, st, 1'b0); chk("loop_en_set", st, 32'h102);
    txs.delete(); rec = 1'b1;
    b = $urandom_range(0, 1) ? 8'h5A : 8'($urandom);
    wr(32'h0, {24'b0, b});
    wait_tx_idle(200);
    repeat (10) tick();
    rec = 1'b0;
    rd(32'h4, st, 1'b0); chk("loopback_rxdata", st, {23'b0, 1'b1, b});
    n = 0;
    foreach (txs[i]) if (txs[i] !== 1'b1) n++;
    chk("loopback_txd_held_high", n, 0);
`else
    wr(32'h8, 32'h100);
    rd(32'h8, st, 1'b0); chk("loop_bit_absent", st, 32'h2);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
MMIO responder behind the memory mapper's MMIO window: UART transmitter with TX FIFO plus receiver with a single-byte holding register. CPU loads/stores are decoded into four 32-bit registers. txd/rxd connect to the board serial pins. Completes the MMIO path on the opposite side from the CPU-side mapper.

Parameters:
TX_FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2.
BAUD_DIV_RESET, 868, reset value of BAUD_DIV (clk cycles per bit; 100 MHz / 115200).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high; clears all state.
address  in  32  byte address within MMIO window; only address[3:2] decoded, rest ignored.
write_data  in  32  store data.
write_en  in  1  store strobe, one cycle per store.
read_en  in  1  load strobe; needed for read side effects.
read_data  out  32  combinational from address and current state.
rxd  in  1  serial input, asynchronous, idle high.
txd  out  1  serial output, registered, idle high.

Behaviour:
- Register map, by address[3:2]:
  - 0 TXDATA: write pushes write_data[7:0] into TX FIFO; push when full is dropped; reads 0.
  - 1 RXDATA: read returns {23'b0, rx_valid, rx_byte}; read_en clears rx_valid; writes ignored.
  - 2 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun (sticky), bit4 tx_busy (FSM not IDLE), bit5 rx_frame_err (sticky), others 0. Writing 1 to bit3/bit5 clears that bit.
  - 3 BAUD_DIV: bits[15:0] R/W; upper bits read 0. A value of 0 behaves as 1. New value takes effect at the next bit boundary.
- Reset values: txd=1; read_data reflects reset state (STATUS=0x02); FIFO empty; rx_valid=0; sticky bits=0; BAUD_DIV=BAUD_DIV_RESET; both FSMs IDLE.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state holds txd for exactly BAUD_DIV clocks.
  - IDLE pops the FIFO head and moves to START the cycle after the FIFO is non-empty.
  - Back-to-back bytes: STOP is followed directly by IDLE for 1 cycle, then START.
  - A push in the same cycle as a pop from a full FIFO is accepted.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - IDLE -> START on a synchronised falling edge.
  - START waits BAUD_DIV/2 (floor, minimum 1) clocks, then re-samples. If high, it is a glitch: return to IDLE.
  - DATA samples 8 bits at BAUD_DIV intervals, LSB first.
  - STOP samples after a further BAUD_DIV:
    - stop high and rx_valid=0: load rx_byte, set rx_valid.
    - stop high and rx_valid=1: set rx_overrun, keep the old byte.
    - stop low: set rx_frame_err, drop the byte.
  - Then return to IDLE.
- Simultaneous events:
  - read_en on RXDATA in the same cycle a new byte completes: new byte loaded, rx_valid stays 1, no overrun.
  - Sticky-bit clear and a set in the same cycle: set wins.
- Reset mid-frame: txd returns to 1 the next cycle; any partial RX byte is discarded.
- read_en and write_en in the same cycle: both honoured, independently.

Optional Feature:
UART_LOOPBACK_EN
- Defined: STATUS bit8 is R/W loop_en, reset 0. When set, the RX synchroniser input is txd instead of rxd, and the external txd is held at 1.
- Undefined: bit8 reads 0, writes ignored, rxd always used.

Test Plan:
1. Reset, read STATUS -> 0x00000002. Read BAUD_DIV -> 868. txd=1.
2. Write BAUD_DIV=4, write TXDATA=0xA5 -> txd gives 4 clk low, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then 4 clk high. tx_busy=1 throughout, STATUS bit1 returns to 1.
3. BAUD_DIV=4. Push 17 bytes 0x00..0x10 without waiting -> tx_full asserted after the 16th queued byte (one byte already popped, so byte 0x10 is accepted). Push 18th -> dropped. All accepted bytes appear on txd in order.
4. BAUD_DIV=4. Drive rxd frame for 0x3C -> STATUS bit2=1, RXDATA=0x13C. Read with read_en -> bit2=0.
5. Send two frames (0x11, 0x22) without reading -> RXDATA=0x111, rx_overrun=1. Write STATUS=0x8 -> overrun cleared. Frame with stop bit low -> rx_frame_err=1, rx_valid unchanged. 1-clk low glitch on rxd -> no byte, no error.
6. Reset asserted mid-TX byte -> txd=1 the next cycle, FIFO empty. With UART_LOOPBACK_EN: set loop_en, send 0x5A -> RXDATA=0x15A, external txd stays 1.
